// File: rtl/pipe_skid_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
package pipe_skid_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_skid_perf.sv
// Pair of saturating event counters, cleared only by reset.
module pipe_skid_perf
    import pipe_skid_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_event,
    input  logic                  full_event,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] full_cycles
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            full_cycles  <= '0;
        end else begin
            if (stall_event && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
            if (full_event && !(&full_cycles))
                full_cycles <= full_cycles + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer and flush.
// Optional performance counters are built when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg
    import pipe_skid_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [1:0]            occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] full_cycles
`endif
);

    skid_state_e      state, state_next;
    logic [WIDTH-1:0] main_q, main_next;
    logic [WIDTH-1:0] skid_q, skid_next;
    logic             acc, fire;

    // in_ready comes straight from the state flop, so no ready path crosses stages.
    assign out_valid = (state != SKID_EMPTY);
    assign in_ready  = (state != SKID_FULL);
    assign out_data  = main_q;
    assign acc       = in_valid & in_ready;
    assign fire      = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= SKID_EMPTY;
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end

    always_comb begin
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        occupancy  = 2'd0;
        unique case (state)
            SKID_BUSY: occupancy = 2'd1;
            SKID_FULL: occupancy = 2'd2;
            default:   occupancy = 2'd0;
        endcase
        if (flush) begin
            // A concurrent fire is treated as consumed; a concurrent accept is dropped.
            state_next = SKID_EMPTY;
            main_next  = RESET_VALUE;
            skid_next  = RESET_VALUE;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (acc) begin
                        state_next = SKID_BUSY;
                        main_next  = in_data;
                    end
                end
                SKID_BUSY: begin
                    if (acc && fire) begin
                        main_next = in_data;
                    end else if (acc) begin
                        state_next = SKID_FULL;
                        skid_next  = in_data;
                    end else if (fire) begin
                        state_next = SKID_EMPTY;
                        main_next  = RESET_VALUE;
                    end
                end
                SKID_FULL: begin
                    if (fire) begin
                        state_next = SKID_BUSY;
                        main_next  = skid_q;
                        skid_next  = RESET_VALUE;
                    end
                end
                default: begin
                    state_next = SKID_EMPTY;
                    main_next  = RESET_VALUE;
                    skid_next  = RESET_VALUE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    pipe_skid_perf u_perf (
        .clock        (clock),
        .reset        (reset),
        .stall_event  (out_valid & ~out_ready),
        .full_event   (state == SKID_FULL),
        .stall_cycles (stall_cycles),
        .full_cycles  (full_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg; perf checks run when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_reg;
    import pipe_skid_pkg::*;

    localparam int          W  = 32;
    localparam logic [31:0] RV = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cycles;
    logic [PERF_CNT_W-1:0] full_cycles;
`endif

    int vectors    = 0;
    int miscompares = 0;

    pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .occupancy    (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .full_cycles  (full_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stage(input string tag, input logic ov, input logic ir,
                               input logic [1:0] occ, input logic [31:0] dat);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
        check({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
        check({tag, ".out_data"},  out_data, dat);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_stage("reset", 1'b0, 1'b1, 2'd0, RV);

        // Streaming with out_ready high: one cycle latency, occupancy stays at 1
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
        tick(); check_stage("stream11", 1'b1, 1'b1, 2'd1, 32'h11);
        in_data = 32'h22;
        tick(); check_stage("stream22", 1'b1, 1'b1, 2'd1, 32'h22);
        in_data = 32'h33;
        tick(); check_stage("stream33", 1'b1, 1'b1, 2'd1, 32'h33);
        in_valid = 1'b0;
        tick(); check_stage("drain", 1'b0, 1'b1, 2'd0, RV);

        // Back-pressure: fill skid, extra push ignored, FIFO order on release
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
        tick(); check_stage("pushA", 1'b1, 1'b1, 2'd1, 32'hA);
        in_data = 32'hB;
        tick(); check_stage("pushB", 1'b1, 1'b0, 2'd2, 32'hA);
        in_data = 32'hC;
        tick(); check_stage("pushC_ign", 1'b1, 1'b0, 2'd2, 32'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); check_stage("popA", 1'b1, 1'b1, 2'd1, 32'hB);
        tick(); check_stage("popB", 1'b0, 1'b1, 2'd0, RV);

        // Flush while FULL with a concurrent push
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1A;
        tick(); in_data = 32'h1B;
        tick(); check_stage("full2", 1'b1, 1'b0, 2'd2, 32'h1A);
        flush = 1'b1; in_data = 32'hD;
        tick(); check_stage("flush", 1'b0, 1'b1, 2'd0, RV);
        flush = 1'b0; in_valid = 1'b0;
        tick(); check_stage("post_flush", 1'b0, 1'b1, 2'd0, RV);

        // Asynchronous reset between edges while FULL
        in_valid = 1'b1; in_data = 32'h2A;
        tick(); in_data = 32'h2B;
        tick(); in_valid = 1'b0;
        check_stage("full3", 1'b1, 1'b0, 2'd2, 32'h2A);
        #2 reset = 1'b1;
        #1 check_stage("async_rst", 1'b0, 1'b1, 2'd0, RV);
        tick(); reset = 1'b0;
        check_stage("rst_rel", 1'b0, 1'b1, 2'd0, RV);

`ifdef PIPE_SKID_PERF_EN
        check("perf.stall_rst", stall_cycles, 32'd0);
        check("perf.full_rst",  full_cycles,  32'd0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h3A;
        tick(); in_data = 32'h3B;
        tick(); in_valid = 1'b0;
        repeat (4) tick();
        check("perf.stall5", stall_cycles, 32'd5);
        check("perf.full4",  full_cycles,  32'd4);
        flush = 1'b1;
        tick(); flush = 1'b0;
        tick();
        check("perf.stall_flush", stall_cycles, 32'd6);
        check("perf.full_flush",  full_cycles,  32'd5);
        check_stage("perf.empty", 1'b0, 1'b1, 2'd0, RV);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
